// File: rtl/main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Contents:
//   - widths:    OPCODE_W (IR[31:26]), ALUOP_W (AluOp bus), STATE_W (state register)
//   - opcodes:   Op* constants for every opcode the controller recognises
//   - AluOp:     Alu* codes driven towards the ALU-control decoder
//   - state_e:   FSM state encoding, IDLE=0 .. JAL=13
//   - op_class_e: coarse opcode classes produced by main_ctrl_opdec
package main_ctrl_fsm_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OpRtype = 6'b000000;
  localparam logic [OPCODE_W-1:0] OpJ     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OpJal   = 6'b000011;
  localparam logic [OPCODE_W-1:0] OpBeq   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OpBne   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OpAddi  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OpAddiu = 6'b001001;
  localparam logic [OPCODE_W-1:0] OpSlti  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OpSltiu = 6'b001011;
  localparam logic [OPCODE_W-1:0] OpAndi  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OpOri   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OpXori  = 6'b001110;
  localparam logic [OPCODE_W-1:0] OpLui   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OpLw    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OpSw    = 6'b101011;

  localparam logic [ALUOP_W-1:0] AluAdd   = 4'b0000;
  localparam logic [ALUOP_W-1:0] AluSub   = 4'b0001;
  localparam logic [ALUOP_W-1:0] AluRtype = 4'b0010;
  localparam logic [ALUOP_W-1:0] AluSlti  = 4'b0011;
  localparam logic [ALUOP_W-1:0] AluAndi  = 4'b0100;
  localparam logic [ALUOP_W-1:0] AluOri   = 4'b0101;
  localparam logic [ALUOP_W-1:0] AluXori  = 4'b0110;
  localparam logic [ALUOP_W-1:0] AluLui   = 4'b0111;
  localparam logic [ALUOP_W-1:0] AluSltiu = 4'b1000;

  typedef enum logic [STATE_W-1:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StIExec    = 4'd11,
    StIWb      = 4'd12,
    StJal      = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    ClsIllegal,
    ClsRtype,
    ClsMem,
    ClsBranch,
    ClsJump,
    ClsImm,
    ClsJal
  } op_class_e;

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Control bus between the main control FSM and the multicycle datapath.
// Signals:
//   opcode, mem_ready            datapath -> controller
//   pc_write .. illegal_op       controller -> datapath (enables, mux selects, AluOp)
// Modports:
//   master  controller side (main_ctrl_fsm)
//   slave   datapath side
interface main_ctrl_fsm_if;

  logic [main_ctrl_fsm_pkg::OPCODE_W-1:0] opcode;
  logic                                   mem_ready;
  logic                                   pc_write;
  logic                                   pc_write_eq;
  logic                                   pc_write_ne;
  logic                                   i_or_d;
  logic                                   mem_read;
  logic                                   mem_write;
  logic                                   ir_write;
  logic                                   reg_dst;
  logic                                   reg_write;
  logic                                   mem_to_reg;
  logic                                   link;
  logic                                   ext_zero;
  logic                                   alu_src_a;
  logic [1:0]                             alu_src_b;
  logic [1:0]                             pc_source;
  logic [main_ctrl_fsm_pkg::ALUOP_W-1:0]  alu_op;
  logic                                   illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, link, ext_zero, alu_src_a, alu_src_b,
           pc_source, alu_op, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, link, ext_zero, alu_src_a, alu_src_b,
           pc_source, alu_op, illegal_op
  );

endinterface

// File: rtl/main_ctrl_opdec.sv
// Combinational opcode decoder for the main control FSM.
// Ports:
//   opcode      in   IR[31:26]
//   op_class    out  coarse class selecting the post-DECODE path
//   imm_alu_op  out  AluOp for I-type arithmetic/logic (addi/addiu -> add)
//   ext_zero    out  1 for andi/ori/xori (zero-extended immediate)
//   illegal     out  opcode not supported by this controller
// Build option: CTRL_JAL_EN makes jal a legal class; otherwise it decodes as illegal.
module main_ctrl_opdec
  import main_ctrl_fsm_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class,
  output logic [ALUOP_W-1:0]  imm_alu_op,
  output logic                ext_zero,
  output logic                illegal
);

  always_comb begin
    op_class   = ClsIllegal;
    imm_alu_op = AluAdd;
    case (opcode)
      OpRtype:        op_class = ClsRtype;
      OpLw, OpSw:     op_class = ClsMem;
      OpBeq, OpBne:   op_class = ClsBranch;
      OpJ:            op_class = ClsJump;
`ifdef CTRL_JAL_EN
      OpJal:          op_class = ClsJal;
`else
      OpJal:          op_class = ClsIllegal;
`endif
      OpAddi, OpAddiu: op_class = ClsImm;
      OpSlti:  begin op_class = ClsImm; imm_alu_op = AluSlti;  end
      OpSltiu: begin op_class = ClsImm; imm_alu_op = AluSltiu; end
      OpAndi:  begin op_class = ClsImm; imm_alu_op = AluAndi;  end
      OpOri:   begin op_class = ClsImm; imm_alu_op = AluOri;   end
      OpXori:  begin op_class = ClsImm; imm_alu_op = AluXori;  end
      OpLui:   begin op_class = ClsImm; imm_alu_op = AluLui;   end
      default:        op_class = ClsIllegal;
    endcase
  end

  assign ext_zero = (opcode == OpAndi) || (opcode == OpOri) || (opcode == OpXori);
  assign illegal  = (op_class == ClsIllegal);

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB from the IR opcode and drives datapath enables and the
// 4-bit AluOp for the downstream ALU-control decoder. Memory states stall until mem_ready.
// Ports:
//   clk    in   clock, all state changes on posedge
//   reset  in   asynchronous active-high reset, forces IDLE
//   bus    main_ctrl_fsm_if.master: opcode/mem_ready in, control outputs out
// Build option: CTRL_JAL_EN adds the JAL state (PC <- jump target, $31 <- PC via link).
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
(
  input logic            clk,
  input logic            reset,
  main_ctrl_fsm_if.master bus
);

  state_e             state_q, state_d;
  op_class_e          dec_class;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_ext_zero;
  logic               dec_illegal;

  main_ctrl_opdec u_opdec (
    .opcode     (bus.opcode),
    .op_class   (dec_class),
    .imm_alu_op (dec_alu_op),
    .ext_zero   (dec_ext_zero),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.pc_write    = 1'b0;
    bus.pc_write_eq = 1'b0;
    bus.pc_write_ne = 1'b0;
    bus.i_or_d      = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.link        = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.pc_source   = 2'b00;
    bus.alu_op      = AluAdd;
    bus.illegal_op  = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // Only outputs gated by an input: IR and PC load the cycle the fetch completes.
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StDecode;
        end
      end

      StDecode: begin
        bus.alu_src_b  = 2'b11;
        bus.illegal_op = dec_illegal;
        case (dec_class)
          ClsMem:    state_d = StMemAddr;
          ClsRtype:  state_d = StRExec;
          ClsBranch: state_d = StBranch;
          ClsJump:   state_d = StJump;
          ClsImm:    state_d = StIExec;
`ifdef CTRL_JAL_EN
          ClsJal:    state_d = StJal;
`endif
          default:   state_d = StFetch;
        endcase
      end

      StMemAddr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
      end

      StMemRead: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end

      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = StFetch;
      end

      StMemWrite: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end

      StRExec: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = AluRtype;
        state_d       = StRWb;
      end

      StRWb: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d       = StFetch;
      end

      StBranch: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_op      = AluSub;
        bus.pc_source   = 2'b01;
        bus.pc_write_eq = (bus.opcode == OpBeq);
        bus.pc_write_ne = (bus.opcode == OpBne);
        state_d         = StFetch;
      end

      StJump: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = StFetch;
      end

      StIExec: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = dec_alu_op;
        state_d       = StIWb;
      end

      StIWb: begin
        bus.reg_write = 1'b1;
        state_d       = StFetch;
      end

`ifdef CTRL_JAL_EN
      StJal: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        bus.reg_write = 1'b1;
        bus.link      = 1'b1;
        state_d       = StFetch;
      end
`endif

      // Unused encodings (and JAL when not built in) recover through IDLE.
      default: state_d = StIdle;
    endcase
  end

  // Immediate extension follows the opcode alone; held low in IDLE so reset quiets every output.
  assign bus.ext_zero = dec_ext_zero && (state_q != StIdle);

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed scenarios plus randomized instruction
// streams with random memory stalls, checked cycle by cycle against a per-instruction
// expected-trace model built from the instruction semantics.
module tb_main_ctrl_fsm;
  import main_ctrl_fsm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  main_ctrl_fsm_if bus ();

  main_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic       ext_zero;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic  mr;
    outs_t exp;
    string tag;
  } step_t;

  outs_t got;
  assign got = {bus.pc_write, bus.pc_write_eq, bus.pc_write_ne, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_dst, bus.reg_write, bus.mem_to_reg,
                bus.link, bus.ext_zero, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                bus.alu_op, bus.illegal_op};

  step_t       trace[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic void push(input logic mr, input outs_t o, input string tag);
    step_t s;
    s.mr  = mr;
    s.exp = o;
    s.tag = tag;
    trace.push_back(s);
  endfunction

  // Expected per-cycle outputs for one instruction, starting in FETCH.
  // sf = fetch wait cycles, sm = data-memory wait cycles.
  function automatic void build_trace(input logic [5:0] op, input int sf, input int sm);
    logic [3:0] imm_aop[8] = '{4'h0, 4'h0, 4'h3, 4'h8, 4'h4, 4'h5, 4'h6, 4'h7};
    outs_t b, o;
    bit jal_ok;
`ifdef CTRL_JAL_EN
    jal_ok = 1'b1;
`else
    jal_ok = 1'b0;
`endif
    trace.delete();
    b = '0;
    b.ext_zero = (op == 6'h0c) || (op == 6'h0d) || (op == 6'h0e);

    for (int i = 0; i < sf; i++) begin
      o = b; o.mem_read = 1; o.alu_src_b = 2'b01;
      push(1'b0, o, "fetch_wait");
    end
    o = b; o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = 1; o.pc_write = 1;
    push(1'b1, o, "fetch_done");

    o = b; o.alu_src_b = 2'b11;
    o.illegal_op = !(op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h05 ||
                     (op >= 6'h08 && op <= 6'h0f) || op == 6'h23 || op == 6'h2b ||
                     (op == 6'h03 && jal_ok));
    push(1'($urandom), o, "decode");
    if (o.illegal_op) return;

    if (op == 6'h00) begin
      o = b; o.alu_src_a = 1; o.alu_op = 4'b0010;
      push(1'($urandom), o, "r_exec");
      o = b; o.reg_dst = 1; o.reg_write = 1;
      push(1'($urandom), o, "r_wb");
    end else if (op == 6'h23 || op == 6'h2b) begin
      o = b; o.alu_src_a = 1; o.alu_src_b = 2'b10;
      push(1'($urandom), o, "mem_addr");
      o = b; o.i_or_d = 1;
      if (op == 6'h23) o.mem_read = 1; else o.mem_write = 1;
      for (int i = 0; i < sm; i++) push(1'b0, o, "mem_wait");
      push(1'b1, o, "mem_done");
      if (op == 6'h23) begin
        o = b; o.reg_write = 1; o.mem_to_reg = 1;
        push(1'($urandom), o, "mem_wb");
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = b; o.alu_src_a = 1; o.alu_op = 4'b0001; o.pc_source = 2'b01;
      o.pc_write_eq = (op == 6'h04); o.pc_write_ne = (op == 6'h05);
      push(1'($urandom), o, "branch");
    end else if (op == 6'h02) begin
      o = b; o.pc_write = 1; o.pc_source = 2'b10;
      push(1'($urandom), o, "jump");
    end else if (op == 6'h03) begin
      o = b; o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1; o.link = 1;
      push(1'($urandom), o, "jal");
    end else begin
      o = b; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = imm_aop[op - 6'h08];
      push(1'($urandom), o, "i_exec");
      o = b; o.reg_write = 1;
      push(1'($urandom), o, "i_wb");
    end
  endfunction

  // Entered #1 after the posedge that put the DUT in FETCH; leaves in the same phase.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    build_trace(op, sf, sm);
    for (int i = 0; i < trace.size(); i++) begin
      if (i == 0) bus.opcode = op;
      bus.mem_ready = trace[i].mr;
      @(negedge clk);
      check($sformatf("%s op=%b step=%0d", trace[i].tag, op, i), 32'(got),
            32'(trace[i].exp));
      @(posedge clk);
      #1;
    end
  endtask

  // Reset currently high: release it, expect one quiet IDLE cycle, then enter FETCH.
  task automatic release_reset();
    outs_t f;
    @(posedge clk);
    #1;
    check("reset_held", 32'(got), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(got), 32'(0));
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    f = '0; f.mem_read = 1; f.alu_src_b = 2'b01;
    f.ext_zero = (bus.opcode == 6'h0c) || (bus.opcode == 6'h0d) || (bus.opcode == 6'h0e);
    check("fetch_after_idle", 32'(got), 32'(f));
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legal_ops[15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                                6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};

  initial begin
    outs_t w;
    logic [5:0] op;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    #2;
    check("reset_initial", 32'(got), 32'(0));
    release_reset();

    // Directed scenarios.
    run_instr(6'h00, 0, 0);   // R-type, 4 cycles
    run_instr(6'h23, 0, 2);   // lw with two memory wait cycles, 7 cycles
    run_instr(6'h2b, 1, 0);   // sw with one fetch wait
    run_instr(6'h05, 0, 0);   // bne
    run_instr(6'h04, 0, 0);   // beq
    run_instr(6'h02, 0, 0);   // j
    run_instr(6'h0d, 0, 0);   // ori: zero-extend, alu_op 0101
    run_instr(6'h0b, 0, 0);   // sltiu: sign-extend, alu_op 1000
    run_instr(6'h0f, 0, 0);   // lui
    run_instr(6'h3f, 0, 0);   // illegal
    run_instr(6'h03, 0, 0);   // jal (legal or illegal depending on build)

    // Reset in the middle of a stalled store.
    bus.opcode = 6'h2b;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    w = '0; w.mem_write = 1; w.i_or_d = 1;
    check("mem_write_stalled", 32'(got), 32'(w));
    #2 reset = 1'b1;
    #1 check("reset_mid_write", 32'(got), 32'(0));
    release_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 14)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
